// File: rtl/spi_slave_mem_burst_if.sv
// SPI slave serial bus: select and MOSI from the master, read data and status back.
interface spi_slave_mem_burst_if;
  logic ss_n;
  logic MOSI;
  logic MISO;
  logic valid_MISO;
  logic sready;

  modport master (
    output ss_n,
    output MOSI,
    input  MISO,
    input  valid_MISO,
    input  sready
  );

  modport slave (
    input  ss_n,
    input  MOSI,
    output MISO,
    output valid_MISO,
    output sready
  );
endinterface

// File: rtl/spi_slave_mem_burst.sv
// SPI slave with an integrated register file: pointer set, burst write, burst read.
// One MOSI/MISO bit per clk; dropping ss_n mid-frame discards any partial word.
module spi_slave_mem_burst #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_slave_mem_burst_if.slave spi
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W);
  localparam logic [ADDR_W-1:0] PTR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RD_WAIT, RDATA, DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              cmd_hi;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-2:0] addr_shift;
  logic [DATA_W-2:0] data_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;

  logic [ADDR_W-1:0] addr_word;
  logic [DATA_W-1:0] data_word;
  logic              addr_last;
  logic              data_last;
  logic              wr_en;

  // The word being completed includes the bit currently on MOSI.
  assign addr_word = {addr_shift, spi.MOSI};
  assign data_word = {data_shift, spi.MOSI};
  assign addr_last = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));
  assign wr_en     = (state == WDATA) && !spi.ss_n && data_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (!spi.ss_n) state_nxt = CMD;
    end else if (spi.ss_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        CMD: begin
          case ({cmd_hi, spi.MOSI})
            2'b01:   state_nxt = WDATA;
            2'b11:   state_nxt = RD_WAIT;
            default: state_nxt = ADDR;
          endcase
        end
        ADDR:    if (addr_last) state_nxt = DRAIN;
        RD_WAIT: state_nxt = RDATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    spi.sready     = 1'b0;
    spi.valid_MISO = 1'b0;
    spi.MISO       = 1'b0;
    case (state)
      IDLE:  spi.sready = 1'b1;
      RDATA: begin
        spi.valid_MISO = 1'b1;
        spi.MISO       = tx_shift[DATA_W-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_hi     <= 1'b0;
      bit_cnt    <= '0;
      addr_shift <= '0;
      data_shift <= '0;
      tx_shift   <= '0;
      waddr      <= '0;
      raddr      <= '0;
    end else if (spi.ss_n) begin
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_hi  <= spi.MOSI;
          bit_cnt <= '0;
        end
        ADDR: begin
          addr_shift <= addr_word[ADDR_W-2:0];
          if (addr_last) begin
            bit_cnt <= '0;
            if (cmd_hi) raddr <= addr_word;
            else        waddr <= addr_word;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        WDATA: begin
          data_shift <= data_word[DATA_W-2:0];
          if (data_last) begin
            bit_cnt <= '0;
            waddr   <= waddr + PTR_STEP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        RD_WAIT: begin
          tx_shift <= mem[raddr];
          raddr    <= raddr + PTR_STEP;
          bit_cnt  <= '0;
        end
        RDATA: begin
          // Reload on the last bit so consecutive words stream without a gap.
          if (data_last) begin
            tx_shift <= mem[raddr];
            raddr    <= raddr + PTR_STEP;
            bit_cnt  <= '0;
          end else begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= data_word;
  end

endmodule

// File: tb/tb_spi_slave_mem_burst.sv
// Bench for spi_slave_mem_burst: an auto-increment instance and a fixed-pointer instance.
module tb_spi_slave_mem_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  spi_slave_mem_burst_if bus_a();
  spi_slave_mem_burst_if bus_b();

  spi_slave_mem_burst #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (bus_a.slave)
  );

  spi_slave_mem_burst #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (bus_b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic exp_a[$];
  logic exp_b[$];
  logic e_a;
  logic e_b;

  // Scoreboards: every bit flagged valid must match the next expected bit.
  always @(negedge clk) begin
    if (bus_a.valid_MISO === 1'b1) begin
      n_cmp++;
      if (exp_a.size() == 0) begin
        n_bad++;
        $display("FAIL miso_a_unexpected: got valid_MISO=1 MISO=%b, required no read data", bus_a.MISO);
      end else begin
        e_a = exp_a.pop_front();
        if (bus_a.MISO !== e_a) begin
          n_bad++;
          $display("FAIL miso_a_bit @%0t: got %b, required %b", $time, bus_a.MISO, e_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.valid_MISO === 1'b1) begin
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_bad++;
        $display("FAIL miso_b_unexpected: got valid_MISO=1 MISO=%b, required no read data", bus_b.MISO);
      end else begin
        e_b = exp_b.pop_front();
        if (bus_b.MISO !== e_b) begin
          n_bad++;
          $display("FAIL miso_b_bit @%0t: got %b, required %b", $time, bus_b.MISO, e_b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
    $fatal(1);
  end

  task automatic drive(input int w, input logic s, input logic m);
    @(negedge clk);
    if (w == 0) begin
      bus_a.ss_n = s;
      bus_a.MOSI = m;
    end else begin
      bus_b.ss_n = s;
      bus_b.MOSI = m;
    end
  endtask

  task automatic send_bits(input int w, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive(w, 1'b0, v[i]);
  endtask

  task automatic set_ptr(input int w, input logic is_read, input logic [7:0] addr);
    send_bits(w, {30'd0, is_read, 1'b0}, 2);
    send_bits(w, {24'd0, addr}, 8);
    drive(w, 1'b1, 1'b0);
  endtask

  task automatic write_frame(input int w, input logic [31:0] words, input int n);
    send_bits(w, 32'b01, 2);
    for (int i = n - 1; i >= 0; i--) send_bits(w, {24'd0, words[8*i +: 8]}, 8);
    drive(w, 1'b1, 1'b0);
  endtask

  task automatic read_frame(input int w, input logic [31:0] words, input int n);
    int left;
    for (int i = n - 1; i >= 0; i--) begin
      for (int b = 7; b >= 0; b--) begin
        if (w == 0) exp_a.push_back(words[8*i + b]);
        else        exp_b.push_back(words[8*i + b]);
      end
    end
    send_bits(w, 32'b11, 2);
    repeat (8 * n) drive(w, 1'b0, 1'b0);
    drive(w, 1'b1, 1'b0);
    #1;
    left = (w == 0) ? exp_a.size() : exp_b.size();
    n_cmp++;
    if (left !== 0) begin
      n_bad++;
      $display("FAIL read_drain_%0d: got %0d read bits not delivered, required 0", w, left);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (bus_a.sready !== 1'b1) begin
      n_bad++; $display("FAIL reset_sready: got %b, required 1", bus_a.sready);
    end
    n_cmp++;
    if (bus_a.valid_MISO !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b, required 0", bus_a.valid_MISO);
    end
    n_cmp++;
    if (bus_a.MISO !== 1'b0) begin
      n_bad++; $display("FAIL reset_miso: got %b, required 0", bus_a.MISO);
    end
    n_cmp++;
    if (bus_b.sready !== 1'b1) begin
      n_bad++; $display("FAIL reset_sready_b: got %b, required 1", bus_b.sready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_raddr_abort;
    write_frame(0, 32'h5A, 1);
    send_bits(0, 32'b10, 2);
    send_bits(0, 32'hF, 4);
    drive(0, 1'b1, 1'b0);
    n_cmp++;
    if (bus_a.sready !== 1'b0) begin
      n_bad++; $display("FAIL abort_sready_busy: got %b, required 0", bus_a.sready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_a.sready !== 1'b1) begin
      n_bad++; $display("FAIL abort_sready_back: got %b, required 1", bus_a.sready);
    end
    read_frame(0, 32'h5A, 1);
  endtask

  task automatic test_burst;
    set_ptr(0, 1'b0, 8'h10);
    write_frame(0, 32'hA53C, 2);
    set_ptr(0, 1'b1, 8'h10);
    read_frame(0, 32'hA53C, 2);
    @(negedge clk);
    n_cmp++;
    if (bus_a.valid_MISO !== 1'b0) begin
      n_bad++; $display("FAIL burst_valid_after: got %b, required 0", bus_a.valid_MISO);
    end
    n_cmp++;
    if (bus_a.MISO !== 1'b0) begin
      n_bad++; $display("FAIL burst_miso_after: got %b, required 0", bus_a.MISO);
    end
    n_cmp++;
    if (bus_a.sready !== 1'b1) begin
      n_bad++; $display("FAIL burst_sready_after: got %b, required 1", bus_a.sready);
    end
  endtask

  task automatic test_reset_midstream;
    set_ptr(0, 1'b1, 8'h10);
    exp_a.push_back(1'b1);
    send_bits(0, 32'b11, 2);
    drive(0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0);
    #2;
    n_cmp++;
    if (bus_a.valid_MISO !== 1'b1 || bus_a.MISO !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_pre: got valid=%b MISO=%b, required 1 1", bus_a.valid_MISO, bus_a.MISO);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_a.MISO !== 1'b0) begin
      n_bad++; $display("FAIL midreset_miso: got %b, required 0", bus_a.MISO);
    end
    n_cmp++;
    if (bus_a.valid_MISO !== 1'b0) begin
      n_bad++; $display("FAIL midreset_valid: got %b, required 0", bus_a.valid_MISO);
    end
    n_cmp++;
    if (bus_a.sready !== 1'b1) begin
      n_bad++; $display("FAIL midreset_sready: got %b, required 1", bus_a.sready);
    end
    exp_a.delete();
    drive(0, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap;
    set_ptr(0, 1'b0, 8'hFF);
    write_frame(0, 32'h1122, 2);
    set_ptr(0, 1'b1, 8'hFF);
    read_frame(0, 32'h1122, 2);
    set_ptr(0, 1'b1, 8'h00);
    read_frame(0, 32'h22, 1);
  endtask

  task automatic test_write_abort;
    set_ptr(0, 1'b0, 8'h05);
    write_frame(0, 32'h77, 1);
    set_ptr(0, 1'b0, 8'h05);
    send_bits(0, 32'b01, 2);
    send_bits(0, 32'b10110, 5);
    drive(0, 1'b1, 1'b0);
    set_ptr(0, 1'b1, 8'h05);
    read_frame(0, 32'h77, 1);
    write_frame(0, 32'h99, 1);
    set_ptr(0, 1'b1, 8'h05);
    read_frame(0, 32'h99, 1);
  endtask

  task automatic test_no_inc;
    set_ptr(1, 1'b0, 8'h03);
    write_frame(1, 32'h0102, 2);
    set_ptr(1, 1'b1, 8'h03);
    read_frame(1, 32'h0202, 2);
  endtask

  task automatic test_back_to_back;
    set_ptr(0, 1'b0, 8'h40);
    write_frame(0, 32'hC3_5F_E1, 3);
    set_ptr(0, 1'b1, 8'h40);
    read_frame(0, 32'hC3_5F_E1, 3);
  endtask

  initial begin
    bus_a.ss_n = 1'b1;
    bus_a.MOSI = 1'b0;
    bus_b.ss_n = 1'b1;
    bus_b.MOSI = 1'b0;
    test_reset();
    test_raddr_abort();
    test_burst();
    test_reset_midstream();
    test_wrap();
    test_write_abort();
    test_no_inc();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
